mem_valid_start_bridge: RTL and testbench
=========================================

# mem_valid_start_bridge

Bridges the PicoRV32 native memory port (mem_valid/mem_ready) onto a start/busy/done memory backend such as the SRAM adapter path. It captures one CPU request and issues a single-cycle start with command, address, data and byte strobes. It then waits for done, returns the read data with a one-cycle mem_ready, and recovers from a hung backend through a bounded timeout. It sits between the CPU core and any start/busy/done slave in the memory map.

## Interface
- TIMEOUT_CYCLES, 1024: WAIT-state cycles before a request is abandoned; legal range 2..65535.
- TIMEOUT_RDATA, 32'hDEAD_BEEF: value returned on mem_rdata for a timed-out request.
- clk  in  1  system clock; all logic on rising edge.
- resetn  in  1  reset; **asynchronous, active-low**.
- mem_valid  in  1  CPU request valid; must be held until mem_ready.
- mem_addr  in  32  CPU byte address.
- mem_wdata  in  32  CPU write data.
- mem_wstrb  in  4  byte strobes; 4'b0000 means read.
- mem_ready  out  1  one-cycle completion pulse to the CPU.
- mem_rdata  out  32  read data; valid while mem_ready is high.
- start  out  1  one-cycle request pulse to the backend.
- cmd  out  8  8'h52 for read, 8'h57 for write.
- addr_out  out  32  latched address.
- data_out  out  32  latched write data.
- wstrb_out  out  4  latched strobes.
- busy  in  1  backend busy.
- done  in  1  backend completion pulse.
- result  in  32  backend read data; sampled when done is high.
- timeout_err  out  1  one-cycle pulse when a request times out.

## Operation
- Reset values: mem_ready=0, mem_rdata=0, start=0, cmd=0, addr_out=0, data_out=0, wstrb_out=0, timeout_err=0, state=IDLE, timeout counter=0.
- IDLE: if mem_valid=1, latch addr/wdata/wstrb into the *_out registers and set cmd from (mem_wstrb!=0), then go to ISSUE. done/busy are ignored in IDLE, so a stale done is dropped.
- ISSUE: if busy=0, drive start=1 for exactly one cycle, clear the counter and go to WAIT. If busy=1, hold in ISSUE with start=0; ISSUE time is not counted toward timeout.
- WAIT: the counter increments each cycle.
  - If done=1, mem_rdata<=result (for writes too), mem_ready<=1, then go to RESP.
  - Else, if the counter reaches TIMEOUT_CYCLES-1, mem_rdata<=TIMEOUT_RDATA, mem_ready<=1, timeout_err<=1, then go to RESP.
  - done and timeout in the same cycle: done wins and timeout_err stays 0.
- RESP: mem_ready and timeout_err return to 0, and the state goes to IDLE. mem_valid is not sampled in RESP, which prevents re-issuing the request that just completed.
- If mem_valid drops mid-request (outside the protocol), the transaction still completes on the backend and mem_ready still pulses once.
- *_out registers hold their value until the next capture. mem_rdata holds until the next completion.
- Asserting resetn low at any point immediately returns all outputs to reset values; a pending backend operation is abandoned.

## Timing
- Request sampled at edge E0 → start high in cycle E0+1 (busy=0) → done earliest at E0+2 → mem_ready high in the cycle after done is sampled.
- Minimum CPU latency: mem_valid rise to mem_ready = 3 cycles. Back-to-back requests: next start no earlier than 2 cycles after mem_ready.
- Timeout: mem_ready arrives TIMEOUT_CYCLES cycles after the start pulse.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Package mem_bridge_pkg holds the CMD_READ=8'h52 and CMD_WRITE=8'h57 constants and the 2-bit state encoding (IDLE=0, ISSUE=1, WAIT=2, RESP=3).
- Sub-module bridge_timeout_counter provides a 16-bit counter with clear and enable inputs and a terminal-count output at TIMEOUT_CYCLES-1; it uses the same clk/resetn.

## Test plan
- Read: mem_valid with addr=0x0000_1000 and wstrb=0. A backend model returns done with result=0x1234_5678 three cycles after start → start has one pulse, cmd=8'h52, mem_rdata=0x1234_5678 during a one-cycle mem_ready, timeout_err=0.
- Byte write: addr=0x0000_2003, wdata=0xAABB_CCDD, wstrb=4'b1000 → cmd=8'h57, data_out=0xAABB_CCDD, wstrb_out=4'b1000, mem_ready pulses once.
- Busy hold: busy=1 for 5 cycles when a request arrives → start is delayed until busy=0, exactly one start pulse, and no timeout even with TIMEOUT_CYCLES=4.
- Timeout: TIMEOUT_CYCLES=8 and done never asserts → mem_ready and timeout_err pulse together 8 cycles after start, mem_rdata=0xDEAD_BEEF. A late done in IDLE is ignored and no extra mem_ready occurs.
- Collision: done arrives on the terminal-count cycle → mem_rdata=result and timeout_err=0.
- Reset mid-WAIT: resetn pulses low asynchronously (between clock edges) → all outputs go to 0 immediately, and the next request completes normally.

Source files
------------

// File: rtl/mem_bridge_pkg.sv
// Shared constants and state encoding for the
// PicoRV32 mem_valid -> start/busy/done bridge.
package mem_bridge_pkg;

  localparam logic [7:0] CMD_READ  = 8'h52;
  localparam logic [7:0] CMD_WRITE = 8'h57;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

endpackage

// File: rtl/bridge_timeout_counter.sv
// WAIT-state cycle counter; tc flags the last
// cycle a request may wait before it is abandoned.
module bridge_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic resetn,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  localparam logic [15:0] LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] count;

  // clear has priority so a fresh request starts at zero
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      count <= '0;
    else if (clear)
      count <= '0;
    else if (enable)
      count <= count + 16'd1;
  end

  assign tc = (count == LAST);

endmodule

// File: rtl/mem_valid_start_bridge.sv
// PicoRV32 native memory port to start/busy/done
// backend bridge with bounded completion timeout.
module mem_valid_start_bridge
  import mem_bridge_pkg::*;
#(
  parameter int          TIMEOUT_CYCLES = 1024,
  parameter logic [31:0] TIMEOUT_RDATA  = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        mem_valid,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic        start,
  output logic [7:0]  cmd,
  output logic [31:0] addr_out,
  output logic [31:0] data_out,
  output logic [3:0]  wstrb_out,
  input  logic        busy,
  input  logic        done,
  input  logic [31:0] result,
  output logic        timeout_err
);

  state_t state;
  state_t state_n;

  logic capture;
  logic fire;
  logic fin_done;
  logic fin_to;
  logic tc;

  bridge_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_tmo (
    .clk   (clk),
    .resetn(resetn),
    .clear (fire),
    .enable(state == S_WAIT),
    .tc    (tc)
  );

  // state register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      state <= S_IDLE;
    else
      state <= state_n;
  end

  // next state and per-cycle action strobes
  always_comb begin
    state_n  = state;
    capture  = 1'b0;
    fire     = 1'b0;
    fin_done = 1'b0;
    fin_to   = 1'b0;
    case (state)
      S_IDLE: begin
        if (mem_valid) begin
          capture = 1'b1;
          state_n = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (!busy) begin
          fire    = 1'b1;
          state_n = S_WAIT;
        end
      end
      S_WAIT: begin
        if (done) begin
          fin_done = 1'b1;
          state_n  = S_RESP;
        end else if (tc) begin
          fin_to  = 1'b1;
          state_n = S_RESP;
        end
      end
      S_RESP: state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // registered outputs; pulses last one cycle
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mem_ready   <= 1'b0;
      mem_rdata   <= '0;
      start       <= 1'b0;
      cmd         <= '0;
      addr_out    <= '0;
      data_out    <= '0;
      wstrb_out   <= '0;
      timeout_err <= 1'b0;
    end else begin
      start       <= fire;
      mem_ready   <= fin_done | fin_to;
      timeout_err <= fin_to;
      if (capture) begin
        addr_out  <= mem_addr;
        data_out  <= mem_wdata;
        wstrb_out <= mem_wstrb;
        cmd       <= (mem_wstrb != 4'b0000) ? CMD_WRITE : CMD_READ;
      end
      if (fin_done)
        mem_rdata <= result;
      else if (fin_to)
        mem_rdata <= TIMEOUT_RDATA;
    end
  end

endmodule

// File: tb/tb_mem_valid_start_bridge.sv
// Self-checking bench for mem_valid_start_bridge:
// directed corner cases plus random transactions.
module tb_mem_valid_start_bridge;

  localparam int T = 8;
  localparam logic [31:0] TO_DATA = 32'hDEAD_BEEF;

  logic        clk;
  logic        resetn;
  logic        mem_valid;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        start;
  logic [7:0]  cmd;
  logic [31:0] addr_out;
  logic [31:0] data_out;
  logic [3:0]  wstrb_out;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        timeout_err;

  int checks;
  int errors;

  mem_valid_start_bridge #(
    .TIMEOUT_CYCLES(T),
    .TIMEOUT_RDATA (TO_DATA)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .mem_valid  (mem_valid),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wstrb  (mem_wstrb),
    .mem_ready  (mem_ready),
    .mem_rdata  (mem_rdata),
    .start      (start),
    .cmd        (cmd),
    .addr_out   (addr_out),
    .data_out   (data_out),
    .wstrb_out  (wstrb_out),
    .busy       (busy),
    .done       (done),
    .result     (result),
    .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".mem_ready"}, 32'(mem_ready), 0);
    chk({tag, ".mem_rdata"}, mem_rdata, 0);
    chk({tag, ".start"}, 32'(start), 0);
    chk({tag, ".cmd"}, 32'(cmd), 0);
    chk({tag, ".addr_out"}, addr_out, 0);
    chk({tag, ".data_out"}, data_out, 0);
    chk({tag, ".wstrb_out"}, 32'(wstrb_out), 0);
    chk({tag, ".timeout_err"}, 32'(timeout_err), 0);
  endtask

  // One CPU request. b: ISSUE cycles with busy high.
  // d: done delay after start is seen (<0: never).
  // Expected timing is derived from the protocol:
  // start seen b+2 cycles after request, response
  // d+1 cycles after start, or T cycles on timeout.
  task automatic run_txn(input string tag,
                         input logic [31:0] a,
                         input logic [31:0] wd,
                         input logic [3:0] ws,
                         input int b,
                         input int d,
                         input logic [31:0] res);
    int s, r, last;
    bit to;
    int n_start, n_ready, n_to;
    int start_at, ready_at;
    logic [31:0] o_addr, o_data, o_rdata;
    logic [7:0] o_cmd;
    logic [3:0] o_ws;
    logic o_to;
    s  = b + 2;
    to = (d < 0) || (d >= T);
    r  = to ? s + T : s + d + 1;
    last = r;
    if (d >= 0 && s + d > last) last = s + d;
    last += 3;
    n_start = 0; n_ready = 0; n_to = 0;
    start_at = -1; ready_at = -1;
    o_addr = 'x; o_data = 'x; o_rdata = 'x;
    o_cmd = 'x; o_ws = 'x; o_to = 'x;
    for (int i = 0; i <= last; i++) begin
      @(negedge clk);
      if (start) begin
        n_start++;
        start_at = i;
        o_cmd  = cmd;
        o_addr = addr_out;
        o_data = data_out;
        o_ws   = wstrb_out;
      end
      if (timeout_err) n_to++;
      if (mem_ready) begin
        n_ready++;
        ready_at = i;
        o_rdata  = mem_rdata;
        o_to     = timeout_err;
      end
      if (i == 0) begin
        mem_valid = 1'b1;
        mem_addr  = a;
        mem_wdata = wd;
        mem_wstrb = ws;
      end
      if (mem_ready) begin
        mem_valid = 1'b0;
        mem_addr  = ~a;
        mem_wdata = ~wd;
        mem_wstrb = ~ws;
      end
      busy   = (i <= b);
      done   = (d >= 0) && (i == s + d);
      result = done ? res : $urandom;
    end
    done = 1'b0;
    busy = 1'b0;
    chk({tag, ".n_start"}, n_start, 1);
    chk({tag, ".start_at"}, start_at, s);
    chk({tag, ".n_ready"}, n_ready, 1);
    chk({tag, ".ready_at"}, ready_at, r);
    chk({tag, ".cmd"}, 32'(o_cmd),
        (ws != 0) ? 32'h57 : 32'h52);
    chk({tag, ".addr_out"}, o_addr, a);
    chk({tag, ".data_out"}, o_data, wd);
    chk({tag, ".wstrb_out"}, 32'(o_ws), 32'(ws));
    chk({tag, ".rdata"}, o_rdata, to ? TO_DATA : res);
    chk({tag, ".to_at_ready"}, 32'(o_to), 32'(to));
    chk({tag, ".n_to"}, n_to, int'(to));
    chk({tag, ".addr_hold"}, addr_out, a);
    chk({tag, ".rdata_hold"}, mem_rdata,
        to ? TO_DATA : res);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    resetn = 1'b0;
    mem_valid = 1'b0;
    mem_addr = '0;
    mem_wdata = '0;
    mem_wstrb = '0;
    busy = 1'b0;
    done = 1'b0;
    result = '0;
    #2;
    chk_zero("reset");
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;

    run_txn("read", 32'h0000_1000, 32'h0, 4'b0000,
            0, 2, 32'h1234_5678);
    run_txn("bytewr", 32'h0000_2003, 32'hAABB_CCDD,
            4'b1000, 0, 1, 32'h0BAD_F00D);
    run_txn("earliest", 32'h0000_0040, 32'h1,
            4'b1111, 0, 0, 32'h5555_AAAA);
    run_txn("busyhold", 32'h0000_3000, 32'h2,
            4'b0000, 10, 2, 32'hCAFE_0001);
    run_txn("timeout", 32'h0000_4000, 32'h3,
            4'b0000, 0, T + 2, 32'h1111_2222);
    run_txn("hung", 32'h0000_4004, 32'h4,
            4'b0011, 1, -1, 32'h0);
    run_txn("collide", 32'h0000_5000, 32'h5,
            4'b0000, 0, T - 1, 32'h7777_8888);
    run_txn("lastok", 32'h0000_6000, 32'h6,
            4'b0100, 2, T - 2, 32'h9999_0000);

    for (int k = 0; k < 30; k++) begin
      run_txn("rand", $urandom, $urandom,
              4'($urandom_range(0, 15)),
              $urandom_range(0, 3),
              $urandom_range(0, T + 2), $urandom);
    end

    // async reset in the middle of WAIT
    @(negedge clk);
    mem_valid = 1'b1;
    mem_addr  = 32'h0000_7000;
    mem_wdata = 32'h1357_9BDF;
    mem_wstrb = 4'b1111;
    repeat (4) @(negedge clk);
    mem_valid = 1'b0;
    #2;
    resetn = 1'b0;
    #1;
    chk_zero("midreset");
    @(negedge clk);
    chk_zero("midreset_hold");
    resetn = 1'b1;
    run_txn("afterrst", 32'h0000_8000, 32'h0,
            4'b0000, 0, 3, 32'h2468_ACE0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
